// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_perf_counter.sv
// 32-bit saturating event counter; counts one per cycle with inc_i high.
// Latency: count_o updates on the edge after inc_i; no backpressure.
module fetch_perf_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 32'd0;
        end else if (inc_i && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, combinational imem read, registered IF/ID slot with valid/ready.
// First capture two edges after reset release; one instr/cycle; slot holds while id_ready=0.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/stall counters.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int              XLEN             = 32,
    parameter logic [XLEN-1:0] RESET_PC         = '0,
    parameter int              IMEM_DEPTH_WORDS = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic            fetch_fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall_cycles
`endif
);

    localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_DEPTH_WORDS * INSTR_BYTES);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            vld_q, vld_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic [XLEN-1:0] ipc4_q, ipc4_d;
    logic            fault_q, fault_d;
    logic            target_bad;
    logic            slot_stalled;

    assign target_bad   = (redirect_target[1:0] != 2'b00) || (redirect_target >= IMEM_LIMIT);
    assign slot_stalled = vld_q && !id_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        vld_d   = vld_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        ipc4_d  = ipc4_q;
        fault_d = fault_q;
        unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (redirect_valid) begin
                    // Flush the slot; a bad target leaves PC at the last good address.
                    vld_d   = 1'b0;
                    instr_d = NOP_INSTR;
                    if (target_bad) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else if (slot_stalled) begin
                    state_d = FETCH;
                end else if (pc_q >= IMEM_LIMIT) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    vld_d   = 1'b0;
                    instr_d = NOP_INSTR;
                end else begin
                    vld_d   = 1'b1;
                    instr_d = imem_rdata;
                    ipc_d   = pc_q;
                    ipc4_d  = pc_q + PC_STEP;
                    pc_d    = pc_q + PC_STEP;
                end
            end
            FAULT: state_d = FAULT;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            vld_q   <= 1'b0;
            instr_q <= NOP_INSTR;
            ipc_q   <= RESET_PC;
            ipc4_q  <= RESET_PC + PC_STEP;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            vld_q   <= vld_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
            fault_q <= fault_d;
        end
    end

    assign imem_addr   = pc_q;
    assign id_valid    = vld_q;
    assign id_instr    = instr_q;
    assign id_pc       = ipc_q;
    assign id_pc_plus4 = ipc4_q;
    assign fetch_fault = fault_q;

`ifdef FETCH_PERF_CNT_EN
    logic fetch_active;
    logic capture_evt;
    logic stall_evt;

    assign fetch_active = (state_q == FETCH) && !redirect_valid;
    assign stall_evt    = fetch_active && slot_stalled;
    assign capture_evt  = fetch_active && !slot_stalled && (pc_q < IMEM_LIMIT);

    fetch_perf_counter u_cnt_fetched (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (capture_evt),
        .count_o (perf_fetched)
    );

    fetch_perf_counter u_cnt_stall (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (stall_evt),
        .count_o (perf_stall_cycles)
    );
`endif

endmodule
